// File: rtl/serializer.sv
// Parallel-to-serial shifter, LSB first, with even/odd parity captured at load; bit 0 is on out one cycle after shift starts.
// Backpressure: shift_en low pauses READY/SHIFT with outputs frozen; data_valid is ignored while busy.
module serializer #(
    parameter int DataWIDTH = 8
) (
    input  logic                 serializer_CLK,
    input  logic                 serializer_RST_ASYN,
    input  logic [DataWIDTH-1:0] serializer_data_in,
    input  logic                 serializer_data_valid,
    input  logic                 serializer_par_type,
    input  logic                 serializer_shift_en,
    output logic                 serializer_out,
    output logic                 serializer_done,
    output logic                 serializer_busy,
    output logic                 serializer_parity
);

    localparam int CntW = $clog2(DataWIDTH);
    localparam logic [CntW-1:0] LAST = CntW'(DataWIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READY = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [DataWIDTH-1:0] shreg;
    logic [CntW-1:0]      cnt;
    logic                 par;

    always_ff @(posedge serializer_CLK or negedge serializer_RST_ASYN) begin
        if (!serializer_RST_ASYN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (serializer_data_valid) state_nxt = READY;
            READY:   if (serializer_shift_en)   state_nxt = SHIFT;
            SHIFT:   if (serializer_shift_en && cnt == LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Counter saturates at LAST and is cleared on exit, so it never wraps.
    always_ff @(posedge serializer_CLK or negedge serializer_RST_ASYN) begin
        if (!serializer_RST_ASYN) begin
            shreg <= '0;
            cnt   <= '0;
            par   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (serializer_data_valid) begin
                        shreg <= serializer_data_in;
                        par   <= (^serializer_data_in) ^ serializer_par_type;
                    end
                end
                READY: begin
                    if (serializer_shift_en) begin
                        cnt <= '0;
                    end
                end
                SHIFT: begin
                    if (serializer_shift_en) begin
                        if (cnt == LAST) begin
                            cnt <= '0;
                        end else begin
                            shreg <= shreg >> 1;
                            cnt   <= cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign serializer_out    = (state == SHIFT) & shreg[0];
    assign serializer_done   = (state == SHIFT) & (cnt == LAST);
    assign serializer_busy   = (state == READY) | (state == SHIFT);
    assign serializer_parity = par;

endmodule
